// File: rtl/msg_router_pkg.sv
// Shared types and constants for the host packet router.
package msg_router_pkg;

  localparam int N_DEF       = 12;
  localparam int TIMEOUT_DEF = 50000;

  // Header layout of both RX and TX frames: address byte, then length byte.
  localparam int HDR_ADDR_IDX = 0;
  localparam int HDR_LEN_IDX  = 1;
  localparam int HDR_BYTES    = 2;

  // Longest response drained in one TX frame; longer FIFOs are split.
  localparam int L_MAX = 63;
  localparam int L_W   = $clog2(L_MAX + 1);

  localparam int AW_DEF = $clog2(N_DEF);

  typedef enum logic [1:0] {
    R_ADDR,
    R_LEN,
    R_DATA,
    R_DROP
  } rx_state_e;

  typedef enum logic [2:0] {
    T_SCAN,
    T_HDR_A,
    T_HDR_L,
    T_RD,
    T_WAIT,
    T_DATA
  } tx_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/msg_router_rr_arbiter.sv
// Round-robin pick: first requester at or above ptr_i, wrapping to 0.
// Purely combinational; grant is one-hot and vld_o flags any request.
module rr_arbiter
  import msg_router_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [CW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [CW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = CW'(j);
      end
    end
  end

endmodule

// File: rtl/msg_router.sv
// Host link router: RX frames {addr,len,payload} fan out to channel command FIFOs;
// TX drains channel response FIFOs round-robin into {chan,len,payload} frames.
module msg_router
  import msg_router_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic [7:0]     m_dout,
  output logic [N-1:0]   m_wrreq_bus,
  input  logic [N-1:0]   have_msg_bus,
  input  logic [8*N-1:0] len_bus,
  input  logic [8*N-1:0] s_din_bus,
  output logic [N-1:0]   s_rdreq_bus,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           rx_busy,
  output logic           err_addr,
  output logic           err_timeout
);

  localparam int CW = idx_w(N);
  localparam int TW = idx_w(TIMEOUT);

  // ---------------------------------------------------------------- RX path
  rx_state_e     rx_state_q, rx_state_d;
  logic [7:0]    rx_addr_q, rx_addr_d;
  logic [7:0]    rx_cnt_q, rx_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          addr_bad, rx_tmo, wr_fire, addr_err_fire;
  logic [N-1:0]  wr_oh;

  logic [7:0]    m_dout_q;
  logic [N-1:0]  m_wrreq_q;
  logic          err_addr_q, err_timeout_q;

  assign addr_bad = {1'b0, rx_addr_q} >= 9'(N);
  // A byte arriving in the expiry cycle wins: it restarts the inter-byte window.
  assign rx_tmo   = rx_busy && !rx_valid && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_state_q <= R_ADDR;
      rx_addr_q  <= '0;
      rx_cnt_q   <= '0;
      tmo_q      <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_addr_q  <= rx_addr_d;
      rx_cnt_q   <= rx_cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_addr_d  = rx_addr_q;
    rx_cnt_d   = rx_cnt_q;
    if (rx_valid || !rx_busy || rx_tmo) tmo_d = '0;
    else                                tmo_d = tmo_q + 1'b1;

    case (rx_state_q)
      R_ADDR: if (rx_valid) begin
        rx_addr_d  = rx_data;
        rx_state_d = R_LEN;
      end
      R_LEN: if (rx_valid) begin
        rx_cnt_d = rx_data;
        if (rx_data == 8'd0) rx_state_d = R_ADDR;
        else if (addr_bad)   rx_state_d = R_DROP;
        else                 rx_state_d = R_DATA;
      end
      R_DATA, R_DROP: if (rx_valid) begin
        rx_cnt_d = rx_cnt_q - 8'd1;
        if (rx_cnt_q == 8'd1) rx_state_d = R_ADDR;
      end
      default: rx_state_d = R_ADDR;
    endcase

    if (rx_tmo) rx_state_d = R_ADDR;
  end

  always_comb begin
    rx_busy       = (rx_state_q != R_ADDR);
    wr_fire       = (rx_state_q == R_DATA) && rx_valid;
    addr_err_fire = (rx_state_q == R_LEN) && rx_valid && (rx_data != 8'd0) && addr_bad;
    wr_oh         = '0;
    if (wr_fire) wr_oh = {{(N-1){1'b0}}, 1'b1} << rx_addr_q[CW-1:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_dout_q      <= '0;
      m_wrreq_q     <= '0;
      err_addr_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      if (wr_fire) m_dout_q <= rx_data;
      m_wrreq_q     <= wr_oh;
      err_addr_q    <= addr_err_fire;
      err_timeout_q <= rx_tmo;
    end
  end

  assign m_dout      = m_dout_q;
  assign m_wrreq_bus = m_wrreq_q;
  assign err_addr    = err_addr_q;
  assign err_timeout = err_timeout_q;

  // ---------------------------------------------------------------- TX path
  tx_state_e      tx_state_q, tx_state_d;
  logic [CW-1:0]  ch_q, ch_d, ptr_q, ptr_d;
  logic [N-1:0]   ch_oh_q, ch_oh_d;
  logic [L_W-1:0] len_q, len_d, rem_q, rem_d;
  logic [7:0]     dat_q, dat_d;

  logic [N-1:0]   arb_gnt;
  logic [CW-1:0]  arb_idx;
  logic           arb_vld;
  logic [7:0]     sel_raw;
  logic [L_W-1:0] sel_len;

  rr_arbiter #(.N(N), .CW(CW)) u_arb (
    .req_i (have_msg_bus),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  assign sel_raw = len_bus[8*arb_idx +: 8];
  assign sel_len = (sel_raw > 8'(L_MAX)) ? L_W'(L_MAX) : sel_raw[L_W-1:0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_state_q <= T_SCAN;
      ch_q       <= '0;
      ch_oh_q    <= '0;
      ptr_q      <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      dat_q      <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      ch_q       <= ch_d;
      ch_oh_q    <= ch_oh_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      dat_q      <= dat_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    ch_d       = ch_q;
    ch_oh_d    = ch_oh_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    rem_d      = rem_q;
    dat_d      = dat_q;

    case (tx_state_q)
      T_SCAN: if (arb_vld) begin
        ch_d    = arb_idx;
        ch_oh_d = arb_gnt;
        len_d   = sel_len;
        rem_d   = sel_len;
        ptr_d   = (arb_idx == CW'(N - 1)) ? '0 : arb_idx + 1'b1;
        if (sel_len != '0) tx_state_d = T_HDR_A;
      end
      T_HDR_A: if (tx_ready) tx_state_d = T_HDR_L;
      T_HDR_L: if (tx_ready) tx_state_d = T_RD;
      T_RD:    tx_state_d = T_WAIT;
      T_WAIT: begin
        dat_d      = s_din_bus[8*ch_q +: 8];
        tx_state_d = T_DATA;
      end
      T_DATA: if (tx_ready) begin
        rem_d      = rem_q - 1'b1;
        tx_state_d = (rem_q == L_W'(1)) ? T_SCAN : T_RD;
      end
      default: tx_state_d = T_SCAN;
    endcase
  end

  always_comb begin
    tx_valid    = 1'b0;
    tx_data     = '0;
    s_rdreq_bus = '0;
    case (tx_state_q)
      T_HDR_A: begin tx_valid = 1'b1; tx_data = 8'(ch_q);  end
      T_HDR_L: begin tx_valid = 1'b1; tx_data = 8'(len_q); end
      T_RD:    s_rdreq_bus = ch_oh_q;
      T_DATA:  begin tx_valid = 1'b1; tx_data = dat_q;     end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_msg_router.sv
// Randomized scoreboard bench for msg_router with a queue-level reference model.
module tb_msg_router;

  localparam int N  = 12;
  localparam int TO = 400;

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic [7:0]     rx_data = '0;
  logic           rx_valid = 1'b0;
  logic [7:0]     m_dout;
  logic [N-1:0]   m_wrreq_bus;
  logic [N-1:0]   have_msg_bus = '0;
  logic [8*N-1:0] len_bus = '0;
  logic [8*N-1:0] s_din_bus = '0;
  logic [N-1:0]   s_rdreq_bus;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b0;
  logic           rx_busy, err_addr, err_timeout;

  msg_router #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .m_dout(m_dout), .m_wrreq_bus(m_wrreq_bus), .have_msg_bus(have_msg_bus),
    .len_bus(len_bus), .s_din_bus(s_din_bus), .s_rdreq_bus(s_rdreq_bus),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_busy(rx_busy), .err_addr(err_addr), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard queues: expected channel writes (ch*256+byte) and host TX bytes.
  int exp_wr[$];
  int exp_tx[$];

  // Response FIFO model: fh = DUT read head, mh = reference-model head.
  logic [7:0] fmem [N][256];
  int fh[N], ft[N], mh[N];
  int mp = 0;
  int exp_rd[N], rd_cnt[N];
  int exp_addr_err = 0, addr_err_cnt = 0;
  int exp_to = 0, to_cnt = 0;
  int tx_mode = 0;
  logic [N-1:0] rd_seen = '0;
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = '0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: everything is sampled at negedge, half a cycle from the DUT's edge.
  always @(negedge clk) begin : mon
    int ch, e;
    if (!n_rst) begin
      prev_v  = 1'b0;
      rd_seen = '0;
    end else begin
      if (m_wrreq_bus != '0) begin
        chk($onehot(m_wrreq_bus), "wr_onehot", int'(m_wrreq_bus), 0);
        ch = 0;
        for (int k = 0; k < N; k++) if (m_wrreq_bus[k]) ch = k;
        if (exp_wr.size() == 0) chk(1'b0, "wr_unexpected", ch*256 + int'(m_dout), -1);
        else begin
          e = exp_wr.pop_front();
          chk(e == ch*256 + int'(m_dout), "wr_chan_data", ch*256 + int'(m_dout), e);
        end
      end
      if (err_addr)    addr_err_cnt++;
      if (err_timeout) to_cnt++;

      if (prev_v && !prev_r)
        chk(tx_valid && tx_data == prev_d, "tx_hold", {tx_valid, tx_data}, {1'b1, prev_d});
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) chk(1'b0, "tx_unexpected", int'(tx_data), -1);
        else begin
          e = exp_tx.pop_front();
          chk(e == int'(tx_data), "tx_byte", int'(tx_data), e);
        end
      end
      prev_v = tx_valid;
      prev_r = tx_ready;
      prev_d = tx_data;

      if (s_rdreq_bus != '0) begin
        chk($onehot(s_rdreq_bus), "rd_onehot", int'(s_rdreq_bus), 0);
        for (int k = 0; k < N; k++) if (s_rdreq_bus[k]) begin
          chk(ft[k] > fh[k], "rd_from_empty", ft[k] - fh[k], 1);
          rd_cnt[k]++;
        end
      end
      rd_seen = s_rdreq_bus;
    end
    for (int k = 0; k < N; k++) begin
      have_msg_bus[k]    = (ft[k] != fh[k]);
      len_bus[8*k +: 8]  = (ft[k] - fh[k] > 255) ? 8'd255 : 8'(ft[k] - fh[k]);
    end
  end

  // Response FIFO read port: one-cycle latency after the sampled read strobe.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) if (rd_seen[k] && ft[k] > fh[k]) begin
      s_din_bus[8*k +: 8] <= fmem[k][fh[k] % 256];
      fh[k]++;
    end
  end

  // Host ready: 0 random, 1 toggling, 2 always ready.
  always begin
    @(posedge clk);
    #2;
    case (tx_mode)
      0:       tx_ready = 1'($urandom_range(0, 1));
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input int b);
    rx_data  = 8'(b);
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input int a, input int l);
    if (l != 0 && a >= N) exp_addr_err++;
    send_byte(a);
    send_byte(l);
  endtask

  task automatic send_dat(input int a, input int b);
    if (a < N) exp_wr.push_back(a*256 + b);
    send_byte(b);
  endtask

  task automatic push_fifo(input int k, input int b);
    fmem[k][ft[k] % 256] = 8'(b);
    ft[k]++;
  endtask

  // Reference: serve pending responses in round-robin order from pointer mp.
  task automatic compute_tx();
    int k, l;
    bit any;
    forever begin
      any = 1'b0;
      k   = 0;
      for (int i = 0; i < N; i++)
        if (!any && ft[(mp + i) % N] > mh[(mp + i) % N]) begin
          any = 1'b1;
          k   = (mp + i) % N;
        end
      if (!any) break;
      l = (ft[k] - mh[k] > 63) ? 63 : ft[k] - mh[k];
      exp_tx.push_back(k);
      exp_tx.push_back(l);
      for (int i = 0; i < l; i++) begin
        exp_tx.push_back(int'(fmem[k][mh[k] % 256]));
        mh[k]++;
      end
      exp_rd[k] += l;
      mp = (k + 1) % N;
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0) && t < 20000) begin
      tick();
      t++;
    end
    chk(exp_tx.size() == 0 && exp_wr.size() == 0, name, exp_tx.size() + exp_wr.size(), 0);
    repeat (4) tick();
    for (int k = 0; k < N; k++) chk(rd_cnt[k] == exp_rd[k], "rd_count", rd_cnt[k], exp_rd[k]);
  endtask

  task automatic model_reset();
    exp_tx.delete();
    exp_wr.delete();
    mp = 0;
    for (int k = 0; k < N; k++) begin
      fh[k] = 0; ft[k] = 0; mh[k] = 0; exp_rd[k] = 0; rd_cnt[k] = 0;
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin : main
    int cnt, t0;
    model_reset();
    repeat (3) tick();
    chk(m_wrreq_bus == '0, "rst_wrreq",   int'(m_wrreq_bus), 0);
    chk(m_dout == '0,      "rst_dout",    int'(m_dout), 0);
    chk(tx_valid == 1'b0,  "rst_txvalid", int'(tx_valid), 0);
    chk(tx_data == '0,     "rst_txdata",  int'(tx_data), 0);
    chk(s_rdreq_bus == '0, "rst_rdreq",   int'(s_rdreq_bus), 0);
    chk(rx_busy == 1'b0,   "rst_rxbusy",  int'(rx_busy), 0);
    chk(err_addr == 1'b0,  "rst_erraddr", int'(err_addr), 0);
    chk(err_timeout == 1'b0, "rst_errto", int'(err_timeout), 0);
    n_rst = 1'b1;
    repeat (2) tick();

    // Basic write to channel 3
    send_hdr(3, 2);
    chk(rx_busy == 1'b1, "rxbusy_in_pkt", int'(rx_busy), 1);
    send_dat(3, 8'hAA);
    send_dat(3, 8'h55);
    tick();
    chk(rx_busy == 1'b0, "rxbusy_after_pkt", int'(rx_busy), 0);

    // Invalid address dropped, next packet to channel 0
    send_hdr(12, 2);
    send_dat(12, 8'h11);
    send_dat(12, 8'h22);
    send_hdr(0, 1);
    send_dat(0, 8'h7E);
    send_hdr(2, 0);
    wait_drain("rx_basic_drain");
    chk(addr_err_cnt == exp_addr_err, "err_addr_count", addr_err_cnt, exp_addr_err);

    // Inter-byte timeout with a partially written payload
    send_hdr(5, 3);
    send_dat(5, 8'h01);
    chk(rx_busy == 1'b1, "rxbusy_before_to", int'(rx_busy), 1);
    t0  = to_cnt;
    cnt = 0;
    while (to_cnt == t0 && cnt < TO + 50) begin
      tick();
      cnt++;
    end
    exp_to++;
    chk(cnt >= TO - 2 && cnt <= TO + 3, "timeout_latency", cnt, TO + 1);
    chk(to_cnt == exp_to, "err_timeout_count", to_cnt, exp_to);
    chk(rx_busy == 1'b0, "rxbusy_after_to", int'(rx_busy), 0);
    send_hdr(5, 1);
    send_dat(5, 8'h33);
    wait_drain("rx_after_to_drain");

    // Round-robin: channels 2 and 9 together, twice
    tx_mode = 2;
    push_fifo(2, 8'hC2);
    push_fifo(9, 8'hC9);
    compute_tx();
    wait_drain("rr_first_drain");
    push_fifo(2, 8'hD2);
    push_fifo(9, 8'hD9);
    compute_tx();
    wait_drain("rr_second_drain");

    // Channel 7, two bytes, toggling ready
    tx_mode = 1;
    push_fifo(7, 8'h10);
    push_fifo(7, 8'h20);
    compute_tx();
    wait_drain("ch7_drain");

    // RX and TX on channel 4 at the same time
    tx_mode = 0;
    for (int i = 0; i < 6; i++) push_fifo(4, $urandom_range(0, 255));
    compute_tx();
    send_hdr(4, 6);
    for (int i = 0; i < 6; i++) send_dat(4, $urandom_range(0, 255));
    wait_drain("ch4_concurrent_drain");

    // Response longer than one frame is split at 63 bytes
    tx_mode = 2;
    for (int i = 0; i < 70; i++) push_fifo(11, $urandom_range(0, 255));
    compute_tx();
    wait_drain("long_resp_drain");

    // Randomized concurrent traffic
    fork
      begin : rx_rand
        int a, l;
        for (int p = 0; p < 30; p++) begin
          a = $urandom_range(0, 13);
          l = $urandom_range(0, 5);
          send_hdr(a, l);
          for (int i = 0; i < l; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_dat(a, $urandom_range(0, 255));
          end
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin : tx_rand
        int t;
        for (int r = 0; r < 6; r++) begin
          tx_mode = $urandom_range(0, 2);
          for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
            int k;
            k = $urandom_range(0, N - 1);
            for (int m = 0; m < int'($urandom_range(1, 5)); m++) push_fifo(k, $urandom_range(0, 255));
          end
          compute_tx();
          t = 0;
          while (exp_tx.size() != 0 && t < 3000) begin
            tick();
            t++;
          end
          chk(exp_tx.size() == 0, "tx_round_drain", exp_tx.size(), 0);
          repeat (3) tick();
        end
      end
    join
    wait_drain("random_drain");
    chk(addr_err_cnt == exp_addr_err, "err_addr_count_rand", addr_err_cnt, exp_addr_err);
    chk(to_cnt == exp_to, "err_timeout_count_rand", to_cnt, exp_to);

    // Reset in the middle of a TX response and an RX packet
    tx_mode = 2;
    for (int i = 0; i < 30; i++) push_fifo(3, $urandom_range(0, 255));
    compute_tx();
    send_hdr(4, 10);
    for (int i = 0; i < 3; i++) send_dat(4, $urandom_range(0, 255));
    repeat (3) tick();
    n_rst = 1'b0;
    #1;
    chk(tx_valid == 1'b0,  "midrst_txvalid", int'(tx_valid), 0);
    chk(m_wrreq_bus == '0, "midrst_wrreq",   int'(m_wrreq_bus), 0);
    chk(s_rdreq_bus == '0, "midrst_rdreq",   int'(s_rdreq_bus), 0);
    chk(rx_busy == 1'b0,   "midrst_rxbusy",  int'(rx_busy), 0);
    model_reset();
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (5) tick();
    chk(tx_valid == 1'b0, "postrst_txvalid", int'(tx_valid), 0);
    chk(rx_busy == 1'b0,  "postrst_rxbusy",  int'(rx_busy), 0);
    push_fifo(5, 8'h5A);
    push_fifo(8, 8'h8B);
    compute_tx();
    send_hdr(1, 2);
    send_dat(1, 8'hE1);
    send_dat(1, 8'hE2);
    wait_drain("postrst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
